// File: rtl/hci_prio_scheduler.sv
// Priority scheduler for the wide-vs-narrow HCI arbiter.
// Watches the low-priority (HWPE) branch for stalls. Depending on the policy,
// it temporarily gives that branch priority (S_LOW), then lets the high
// branch recover through a cooldown period (S_COOL) before stalls are
// counted again. A TIMESLICE policy alternates priority on a fixed period.
module hci_prio_scheduler #(
  parameter int N_CHAN = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [1:0]        mode_i,
  input  logic [CNT_W-1:0]  max_stall_i,
  input  logic [CNT_W-1:0]  hold_i,
  input  logic [N_CHAN-1:0] low_req_i,
  input  logic [N_CHAN-1:0] low_gnt_i,
  output logic              invert_prio_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [15:0]       swap_cnt_o
);

  typedef enum logic [1:0] {
    S_HIGH = 2'd0,
    S_LOW  = 2'd1,
    S_COOL = 2'd2,
    S_BAD  = 2'd3
  } state_e;

  localparam logic [1:0] M_FIXED_HIGH = 2'd0;
  localparam logic [1:0] M_FIXED_LOW  = 2'd1;
  localparam logic [1:0] M_ADAPTIVE   = 2'd2;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]      swap_cnt_q, swap_cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             inv_q, inv_d;

  logic             stall;
  logic             low_any;
  logic [CNT_W-1:0] hold_eff;
  logic [CNT_W:0]   stall_inc;
  logic [CNT_W:0]   hold_inc;

  // Saturating increment for the stall counter: it sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // A zero hold behaves like a one-cycle hold everywhere it is used.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  assign stall     = |(low_req_i & ~low_gnt_i);
  assign low_any   = |low_req_i;
  assign hold_eff  = at_least_one(hold_i);
  assign stall_inc = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign hold_inc  = {1'b0, hold_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and counter logic; clear wins over a mode change, which wins over policy.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    swap_cnt_d  = swap_cnt_q;
    mode_d      = mode_q;
    if (clear_i) begin
      state_d     = S_HIGH;
      stall_cnt_d = '0;
      hold_cnt_d  = '0;
      swap_cnt_d  = '0;
      mode_d      = '0;
    end else if (mode_i != mode_q) begin
      mode_d      = mode_i;
      state_d     = S_HIGH;
      stall_cnt_d = '0;
      hold_cnt_d  = '0;
    end else begin
      case (mode_q)
        M_FIXED_HIGH: begin
          state_d     = S_HIGH;
          stall_cnt_d = '0;
          hold_cnt_d  = '0;
        end
        M_FIXED_LOW: begin
          state_d     = S_LOW;
          stall_cnt_d = '0;
          hold_cnt_d  = '0;
        end
        M_ADAPTIVE: begin
          case (state_q)
            S_HIGH: begin
              if (!stall) begin
                stall_cnt_d = '0;
              end else if ((max_stall_i != '0) && (stall_inc >= {1'b0, max_stall_i})) begin
                state_d     = S_LOW;
                stall_cnt_d = '0;
                hold_cnt_d  = hold_eff;
                swap_cnt_d  = swap_cnt_q + 16'd1;
              end else begin
                stall_cnt_d = sat_inc(stall_cnt_q);
              end
            end
            S_LOW: begin
              stall_cnt_d = '0;
              // The low branch gives up priority early once it has nothing pending.
              if (!low_any || (hold_cnt_q <= ONE)) begin
                state_d    = S_COOL;
                hold_cnt_d = hold_eff;
              end else begin
                hold_cnt_d = hold_cnt_q - ONE;
              end
            end
            S_COOL: begin
              stall_cnt_d = '0;
              if (hold_cnt_q <= ONE) begin
                state_d    = S_HIGH;
                hold_cnt_d = '0;
              end else begin
                hold_cnt_d = hold_cnt_q - ONE;
              end
            end
            default: begin
              state_d     = S_HIGH;
              stall_cnt_d = '0;
              hold_cnt_d  = '0;
            end
          endcase
        end
        default: begin
          // TIMESLICE: hold_cnt counts cycles spent in the current slice.
          stall_cnt_d = '0;
          case (state_q)
            S_HIGH, S_LOW: begin
              if (hold_inc >= {1'b0, hold_eff}) begin
                hold_cnt_d = '0;
                if (state_q == S_HIGH) begin
                  state_d    = S_LOW;
                  swap_cnt_d = swap_cnt_q + 16'd1;
                end else begin
                  state_d = S_HIGH;
                end
              end else begin
                hold_cnt_d = hold_inc[CNT_W-1:0];
              end
            end
            default: begin
              state_d    = S_HIGH;
              hold_cnt_d = '0;
            end
          endcase
        end
      endcase
    end
    inv_d = (state_d == S_LOW);
  end

  // State and counter registers, cleared asynchronously by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_HIGH;
      stall_cnt_q <= '0;
      hold_cnt_q  <= '0;
      swap_cnt_q  <= '0;
      mode_q      <= '0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      swap_cnt_q  <= swap_cnt_d;
      mode_q      <= mode_d;
      inv_q       <= inv_d;
    end
  end

  assign invert_prio_o = inv_q;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign swap_cnt_o    = swap_cnt_q;

endmodule

// File: tb/tb_hci_prio_scheduler.sv
// Testbench for hci_prio_scheduler: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_hci_prio_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [1:0]  mode;
  logic [7:0]  max_stall;
  logic [7:0]  hold;
  logic [15:0] req;
  logic [15:0] gnt;
  logic        inv;
  logic [1:0]  state;
  logic [7:0]  stall_cnt;
  logic [15:0] swap_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_state, m_stall, m_rem, m_el, m_swap, m_mode;

  hci_prio_scheduler #(.N_CHAN(16), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .max_stall_i(max_stall), .hold_i(hold), .low_req_i(req), .low_gnt_i(gnt),
    .invert_prio_o(inv), .state_o(state), .stall_cnt_o(stall_cnt), .swap_cnt_o(swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_rem = 0; m_el = 0; m_swap = 0; m_mode = 0;
  endtask

  // One clock edge of the policy, stated in terms of "cycles remaining" and
  // "cycles elapsed" rather than the RTL's counters.
  task automatic model_step();
    bit st;
    int hl;
    st = |(req & ~gnt);
    hl = (hold == 0) ? 1 : int'(hold);
    if (clear) begin
      model_reset();
    end else if (int'(mode) != m_mode) begin
      m_mode = mode; m_state = 0; m_stall = 0; m_rem = 0; m_el = 0;
    end else if (m_mode == 0) begin
      m_state = 0; m_stall = 0;
    end else if (m_mode == 1) begin
      m_state = 1; m_stall = 0;
    end else if (m_mode == 2) begin
      if (m_state == 0) begin
        if (!st) m_stall = 0;
        else if (max_stall != 0 && m_stall + 1 >= int'(max_stall)) begin
          m_state = 1; m_stall = 0; m_rem = hl; m_swap = (m_swap + 1) % 65536;
        end else if (m_stall < 255) m_stall++;
      end else if (m_state == 1) begin
        m_rem--;
        if (req == 0 || m_rem <= 0) begin m_state = 2; m_rem = hl; end
      end else begin
        m_rem--;
        if (m_rem <= 0) begin m_state = 0; m_rem = 0; end
      end
    end else begin
      m_stall = 0;
      m_el++;
      if (m_el >= hl) begin
        m_el = 0;
        if (m_state == 0) begin m_state = 1; m_swap = (m_swap + 1) % 65536; end
        else m_state = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; mode = 2'd0; max_stall = 8'd0; hold = 8'd0;
    req = 16'h0; gnt = 16'h0;
    #2;
    checks++;
    if ({inv, state, stall_cnt, swap_cnt} !== 27'd0)
      begin errors++; $display("FAIL reset_state: inv=%0b state=%0d stall=%0d swap=%0d, want all 0", inv, state, stall_cnt, swap_cnt); end
    repeat (2) @(posedge clk);
    #6 rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if ({inv, state, stall_cnt, swap_cnt} !== 27'd0)
      begin errors++; $display("FAIL reset_release: inv=%0b state=%0d stall=%0d swap=%0d, want all 0", inv, state, stall_cnt, swap_cnt); end
  endtask

  task automatic test_adaptive_trigger();
    int exp_st[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
    int exp_sc[10] = '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0};
    do_clear();
    mode = 2'd2; req = 16'h0; gnt = 16'h0; tick();
    max_stall = 8'd4; hold = 8'd3; req = 16'h0001; gnt = 16'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (state !== exp_st[k][1:0] || stall_cnt !== exp_sc[k][7:0] || inv !== (exp_st[k] == 1))
        begin errors++; $display("FAIL adaptive_edge%0d: state=%0d stall=%0d inv=%0b, want state=%0d stall=%0d", k + 1, state, stall_cnt, inv, exp_st[k], exp_sc[k]); end
      if (k == 3) begin
        checks++;
        if (swap_cnt !== 16'd1)
          begin errors++; $display("FAIL adaptive_swap: swap=%0d, want 1", swap_cnt); end
      end
    end
  endtask

  task automatic test_adaptive_gap();
    logic [15:0] g[5] = '{16'h0, 16'h0, 16'h0, 16'h1, 16'h0};
    int exp_sc[5] = '{1, 2, 3, 0, 1};
    do_clear();
    mode = 2'd2; req = 16'h0; gnt = 16'h0; tick();
    max_stall = 8'd4; hold = 8'd3; req = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      gnt = g[k];
      tick();
      checks++;
      if (stall_cnt !== exp_sc[k][7:0] || state !== 2'd0 || inv !== 1'b0 || swap_cnt !== 16'd0)
        begin errors++; $display("FAIL gap_step%0d: stall=%0d state=%0d inv=%0b swap=%0d, want stall=%0d state=0", k, stall_cnt, state, inv, swap_cnt, exp_sc[k]); end
    end
  endtask

  task automatic test_low_release();
    do_clear();
    mode = 2'd2; req = 16'h0; gnt = 16'h0; tick();
    max_stall = 8'd1; hold = 8'd10; req = 16'h0100; gnt = 16'h0;
    tick(); tick(); tick();
    checks++;
    if (state !== 2'd1 || inv !== 1'b1)
      begin errors++; $display("FAIL release_inlow: state=%0d inv=%0b, want 1/1", state, inv); end
    req = 16'h0;
    tick();
    checks++;
    if (state !== 2'd2 || inv !== 1'b0)
      begin errors++; $display("FAIL release_cool: state=%0d inv=%0b, want 2/0", state, inv); end
  endtask

  task automatic test_timeslice();
    logic exp_inv[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_clear();
    hold = 8'd2; req = 16'hFFFF; gnt = 16'h0; mode = 2'd3;
    tick();
    checks++;
    if (inv !== 1'b0 || state !== 2'd0)
      begin errors++; $display("FAIL ts_entry: inv=%0b state=%0d, want 0/0", inv, state); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (inv !== exp_inv[k] || stall_cnt !== 8'd0)
        begin errors++; $display("FAIL ts_edge%0d: inv=%0b stall=%0d, want inv=%0b stall=0", k + 1, inv, stall_cnt, exp_inv[k]); end
    end
    checks++;
    if (swap_cnt !== 16'd2)
      begin errors++; $display("FAIL ts_swaps: swap=%0d, want 2", swap_cnt); end
    dut.swap_cnt_q = 16'hFFFF;
    m_swap = 65535;
    tick(); tick();
    checks++;
    if (swap_cnt !== 16'h0000 || inv !== 1'b1)
      begin errors++; $display("FAIL ts_wrap: swap=%h inv=%0b, want 0000/1", swap_cnt, inv); end
  endtask

  task automatic test_mode_switch();
    do_clear();
    mode = 2'd1; req = 16'h0; gnt = 16'h0;
    tick(); tick();
    checks++;
    if (state !== 2'd1 || inv !== 1'b1)
      begin errors++; $display("FAIL fixed_low: state=%0d inv=%0b, want 1/1", state, inv); end
    mode = 2'd2; req = 16'h3; max_stall = 8'd1;
    tick();
    checks++;
    if (state !== 2'd0 || inv !== 1'b0 || stall_cnt !== 8'd0)
      begin errors++; $display("FAIL mode_switch: state=%0d inv=%0b stall=%0d, want 0/0/0", state, inv, stall_cnt); end
  endtask

  task automatic test_clear_priority();
    do_clear();
    mode = 2'd2; req = 16'h0; gnt = 16'h0; tick();
    max_stall = 8'd2; hold = 8'd3; req = 16'h1;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 8'd0 || swap_cnt !== 16'd0)
      begin errors++; $display("FAIL clear_prio: state=%0d stall=%0d swap=%0d, want 0/0/0", state, stall_cnt, swap_cnt); end
    tick();
    checks++;
    if (state !== 2'd0 || stall_cnt !== 8'd0)
      begin errors++; $display("FAIL clear_mode_resync: state=%0d stall=%0d, want 0/0", state, stall_cnt); end
  endtask

  task automatic test_saturation();
    do_clear();
    mode = 2'd2; req = 16'h0; gnt = 16'h0; tick();
    max_stall = 8'd0; req = 16'h8000;
    repeat (300) tick();
    checks++;
    if (stall_cnt !== 8'd255 || state !== 2'd0 || swap_cnt !== 16'd0)
      begin errors++; $display("FAIL saturate: stall=%0d state=%0d swap=%0d, want 255/0/0", stall_cnt, state, swap_cnt); end
  endtask

  task automatic test_async_reset();
    do_clear();
    mode = 2'd1; req = 16'h0; gnt = 16'h0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({inv, state, stall_cnt, swap_cnt} !== 27'd0)
      begin errors++; $display("FAIL async_reset: inv=%0b state=%0d stall=%0d swap=%0d, want all 0", inv, state, stall_cnt, swap_cnt); end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        max_stall = 8'($urandom_range(0, 6));
        hold = 8'($urandom_range(0, 5));
      end
      clear = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom) & 16'h000F;
      gnt = 16'($urandom);
      tick();
      checks++;
      if (int'(state) != m_state || int'(stall_cnt) != m_stall || int'(swap_cnt) != m_swap || inv !== (m_state == 1))
        begin errors++; $display("FAIL random_cyc%0d: state=%0d stall=%0d swap=%0d inv=%0b, want state=%0d stall=%0d swap=%0d", c, state, stall_cnt, swap_cnt, inv, m_state, m_stall, m_swap); end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adaptive_trigger();
    test_adaptive_gap();
    test_low_release();
    test_timeslice();
    test_mode_switch();
    test_clear_priority();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hci_prio_scheduler.md
HCI_PRIO_SCHEDULER -- requirements
Module: hci_prio_scheduler

Interface
REQ-001 SHALL have parameter N_CHAN, default 16: number of memory channels observed (one per bank of the wide-vs-narrow arbiter).
REQ-002 SHALL have parameter CNT_W, default 8: width of the stall and hold counters and of the threshold inputs.
REQ-003 SHALL use one clock, with reset asynchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port clear_i, input, 1 bit: synchronous clear; same effect as reset.
REQ-007 SHALL have port mode_i, input, 2 bits: policy select, 0=FIXED_HIGH, 1=FIXED_LOW, 2=ADAPTIVE, 3=TIMESLICE.
REQ-008 SHALL have port max_stall_i, input, CNT_W bits: consecutive low-branch stall cycles that trigger inversion; 0 disables ADAPTIVE inversion.
REQ-009 SHALL have port hold_i, input, CNT_W bits: cycles spent in S_LOW and in S_COOL; also the TIMESLICE period.
REQ-010 SHALL have port low_req_i, input, N_CHAN bits: per-channel request of the low-priority (HWPE) branch.
REQ-011 SHALL have port low_gnt_i, input, N_CHAN bits: per-channel grant of the low-priority branch.
REQ-012 SHALL have port invert_prio_o, output, 1 bit: registered; 1 = low branch currently has priority.
REQ-013 SHALL have port state_o, output, 2 bits: current FSM state encoding.
REQ-014 SHALL have port stall_cnt_o, output, CNT_W bits: current stall counter.
REQ-015 SHALL have port swap_cnt_o, output, 16 bits: number of S_HIGH->S_LOW transitions; wraps modulo 2^16.

Function
REQ-016 SHALL define stall = OR over channels of (low_req_i & ~low_gnt_i), evaluated combinationally each cycle.
REQ-017 SHALL implement FSM states S_HIGH=0, S_LOW=1, S_COOL=2; encoding 3 is unused and SHALL recover to S_HIGH on the next cycle.
REQ-018 SHALL drive invert_prio_o = 1 exactly when the registered state is S_LOW, so the change takes effect one cycle after the triggering edge.
REQ-019 SHALL, in FIXED_HIGH, hold state S_HIGH with invert_prio_o=0; in FIXED_LOW, hold state S_LOW with invert_prio_o=1; in both, hold stall_cnt at 0.
REQ-020 SHALL, in ADAPTIVE and S_HIGH, increment stall_cnt when stall=1 (saturating at 2^CNT_W-1) and clear it to 0 when stall=0.
REQ-021 SHALL, in ADAPTIVE and S_HIGH, move to S_LOW on the edge where stall=1 and stall_cnt+1 >= max_stall_i with max_stall_i != 0; SHALL then clear stall_cnt, load hold_cnt with hold_i, and increment swap_cnt.
REQ-022 SHALL, in S_LOW, decrement hold_cnt each cycle and move to S_COOL when hold_cnt reaches 1, or immediately when low_req_i == 0; hold_i=0 SHALL behave as hold_i=1.
REQ-023 SHALL, in S_COOL, hold stall_cnt at 0, count down hold_i cycles, then return to S_HIGH; hold_i=0 SHALL give a single cooldown cycle.
REQ-024 SHALL, in TIMESLICE, alternate S_HIGH and S_LOW every max(hold_i,1) cycles regardless of stall, skip S_COOL, and increment swap_cnt on each S_HIGH->S_LOW transition.
REQ-025 SHALL, on any change of mode_i (relative to the registered copy), enter S_HIGH on the next edge and clear stall_cnt and hold_cnt; swap_cnt SHALL be preserved.
REQ-026 SHALL, when clear_i and a transition condition coincide, give clear_i precedence.
REQ-027 SHALL sample max_stall_i and hold_i only at the moment they are used (threshold compare, counter load), so mid-state changes do not affect a running hold count.

Reset
REQ-028 SHALL, on rst_i=1 (asynchronous) or clear_i=1 (synchronous), set state=S_HIGH, invert_prio_o=0, stall_cnt_o=0, hold_cnt=0, swap_cnt_o=0, and the registered mode to 0.
REQ-029 SHALL, on reset asserted mid-S_LOW, drop invert_prio_o to 0 without waiting for a clock edge.

Verification
REQ-030 SHALL cover: ADAPTIVE, max_stall=4, hold=3, low_req=0x0001, low_gnt=0 -> stall_cnt 1,2,3 on the first three edges; S_LOW and invert_prio_o=1 after edge 4; swap_cnt=1; S_COOL after 3 more cycles; S_HIGH after 3 further cycles.
REQ-031 SHALL cover: ADAPTIVE, max_stall=4, stall pattern 1,1,1,0,1 -> stall_cnt returns to 0 at the gap and no inversion occurs.
REQ-032 SHALL cover: ADAPTIVE, in S_LOW with hold=10, low_req drops to 0 -> S_COOL on the next edge.
REQ-033 SHALL cover: TIMESLICE, hold=2 -> invert_prio_o sequence 0,0,1,1,0,0,...; swap_cnt increments every 4 cycles; forcing swap_cnt to 0xFFFF then one more swap -> 0x0000.
REQ-034 SHALL cover: mode switched from FIXED_LOW to ADAPTIVE -> S_HIGH and invert_prio_o=0 one cycle later; stall_cnt_o=0.
REQ-035 SHALL cover: rst_i pulsed between clock edges while in S_LOW -> invert_prio_o=0 immediately and all counters 0.
